fetch_unit: RTL and testbench

- Parametrised successor to the single-entry PC/ICache front end: a decoupled instruction fetch unit.
- Issues sequential word reads on the IBus and buffers returned instructions, tagged with their PC, in a QUEUE_DEPTH-entry queue.
- Presents instructions to the decode stage over a valid/ready handshake.
- Accepts a branch/jump redirect from EX2 that flushes the queue and discards any in-flight read.

---
 rtl/cpu_pkg.sv | 9 +
 rtl/fetch_queue.sv | 67 ++++++
 rtl/fetch_unit.sv | 109 ++++++++++
 tb/tb_fetch_unit.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: reset fetch address, instruction width and the NOP
// encoding that decode substitutes while the fetch queue is empty.
package cpu_pkg;

   localparam logic [31:0] INITIAL_PC_DEFAULT = 32'h0000_0000;
   localparam int          INST_WIDTH         = 32;
   localparam logic [INST_WIDTH-1:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous instruction queue of DEPTH entries, each an instruction plus its
// byte PC. Flush empties it in one cycle; the head is read straight from storage.
module fetch_queue
   import cpu_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter int PC_WIDTH = 32
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            push,
   input  logic [INST_WIDTH-1:0]           push_inst,
   input  logic [PC_WIDTH-1:0]             push_pc,
   input  logic                            pop,
   input  logic                            flush,
   output logic [$clog2(DEPTH):0]          count,
   output logic [INST_WIDTH-1:0]           head_inst,
   output logic [PC_WIDTH-1:0]             head_pc
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [INST_WIDTH-1:0] mem_inst [DEPTH];
   logic [PC_WIDTH-1:0]   mem_pc   [DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic                  pop_ok;

   assign pop_ok    = pop && (count != '0);
   assign head_inst = mem_inst[rd_ptr];
   assign head_pc   = mem_pc[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop_ok)
            rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; only entries below count are ever observed.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem_inst[wr_ptr] <= push_inst;
         mem_pc[wr_ptr]   <= push_pc;
      end
   end

   overflow_check: assert property (@(posedge clk) disable iff (!rst_n)
      (push && !pop_ok && !flush) |-> (count < CW'(DEPTH)));

endmodule

// File: rtl/fetch_unit.sv
// Decoupled instruction fetch: sequential IBus word reads feed a tagged queue
// that decode drains over valid/ready; an EX2 redirect flushes and restarts.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int                  PC_WIDTH         = 32,
   parameter logic [PC_WIDTH-1:0] INITIAL_PC_VALUE = PC_WIDTH'(INITIAL_PC_DEFAULT),
   parameter int                  QUEUE_DEPTH      = 4
) (
   input  logic                  i_Clk,
   input  logic                  i_Rst_n,
   input  logic                  i_Redirect,
   input  logic [PC_WIDTH-1:0]   i_RedirectPC,
   output logic                  o_Valid,
   output logic [INST_WIDTH-1:0] o_Inst,
   output logic [PC_WIDTH-1:0]   o_PC,
   input  logic                  i_Ready,
   output logic [PC_WIDTH-3:0]   o_IBus_Address,
   output logic                  o_IBus_Read,
   input  logic [INST_WIDTH-1:0] i_IBus_ReadData,
   input  logic                  i_IBus_WaitReq
);

   localparam int AW = PC_WIDTH - 2;
   localparam int CW = $clog2(QUEUE_DEPTH) + 1;

   logic [AW-1:0] fetch_word;
   logic [AW-1:0] inflight_word;
   logic [AW-1:0] redir_word;
   logic          run;
   logic          inflight;
   logic          discard;
   logic          redir_pend;
   logic          accept;
   logic          held;
   logic          push;
   logic          pop;
   logic [CW-1:0] count;
   logic [CW:0]   occupancy;
   logic          unused_redirect_lsbs;

   assign unused_redirect_lsbs = ^i_RedirectPC[1:0];

   // Issue only from registered state, so a slot freed by a pop is reused a cycle later.
   always_comb begin
      occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
   end

   assign o_IBus_Read    = run && (occupancy < (CW+1)'(QUEUE_DEPTH));
   assign o_IBus_Address = fetch_word;
   assign accept         = o_IBus_Read && !i_IBus_WaitReq;
   assign held           = o_IBus_Read && i_IBus_WaitReq;
   assign push           = inflight && !discard && !i_Redirect;
   assign pop            = o_Valid && i_Ready && !i_Redirect;
   assign o_Valid        = (count != '0);

   always_ff @(posedge i_Clk) begin
      if (!i_Rst_n) begin
         run        <= 1'b0;
         fetch_word <= INITIAL_PC_VALUE[PC_WIDTH-1:2];
         inflight   <= 1'b0;
         discard    <= 1'b0;
         redir_pend <= 1'b0;
      end else begin
         run      <= 1'b1;
         inflight <= accept;
         if (inflight)
            discard <= 1'b0;
         if (i_Redirect && (accept || held))
            discard <= 1'b1;
         // A stalled read must keep its address, so its redirect target waits aside.
         if (i_Redirect) begin
            if (held) begin
               redir_pend <= 1'b1;
            end else begin
               fetch_word <= i_RedirectPC[PC_WIDTH-1:2];
               redir_pend <= 1'b0;
            end
         end else if (accept) begin
            fetch_word <= redir_pend ? redir_word : fetch_word + AW'(1);
            redir_pend <= 1'b0;
         end
      end
   end

   always_ff @(posedge i_Clk) begin
      if (accept)
         inflight_word <= fetch_word;
      if (i_Redirect && held)
         redir_word <= i_RedirectPC[PC_WIDTH-1:2];
   end

   fetch_queue #(
      .DEPTH    (QUEUE_DEPTH),
      .PC_WIDTH (PC_WIDTH)
   ) u_queue (
      .clk       (i_Clk),
      .rst_n     (i_Rst_n),
      .push      (push),
      .push_inst (i_IBus_ReadData),
      .push_pc   ({inflight_word, 2'b00}),
      .pop       (pop),
      .flush     (i_Redirect),
      .count     (count),
      .head_inst (o_Inst),
      .head_pc   (o_PC)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: memory word n holds n, expected PCs are
// queued by the stimulus and popped by a monitor on every decode handshake.
module tb_fetch_unit;

   localparam int          PCW       = 32;
   localparam int          QD        = 4;
   localparam logic [31:0] INIT      = 32'h0000_0000;
   localparam logic [29:0] INIT_WORD = 30'(INIT >> 2);

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        ready = 1'b0;
   logic        waitreq = 1'b0;
   logic [31:0] rdata;
   logic [31:0] junk = '0;
   logic        valid;
   logic [31:0] inst;
   logic [31:0] pc;
   logic [29:0] addr;
   logic        rd;

   always #5 clk = ~clk;

   fetch_unit #(
      .PC_WIDTH         (PCW),
      .INITIAL_PC_VALUE (INIT),
      .QUEUE_DEPTH      (QD)
   ) dut (
      .i_Clk           (clk),
      .i_Rst_n         (rst_n),
      .i_Redirect      (redirect),
      .i_RedirectPC    (redirect_pc),
      .o_Valid         (valid),
      .o_Inst          (inst),
      .o_PC            (pc),
      .i_Ready         (ready),
      .o_IBus_Address  (addr),
      .o_IBus_Read     (rd),
      .i_IBus_ReadData (rdata),
      .i_IBus_WaitReq  (waitreq)
   );

   int tests = 0;
   int fails = 0;

   // Expected delivered PCs, owned by the stimulus side.
   logic [31:0] exp_q[$];
   logic [31:0] next_push = '0;

   // Bus model state, owned by the monitor.
   logic        acc_now = 1'b0;
   logic [29:0] acc_addr = '0;
   logic        resp_valid = 1'b0;
   logic [29:0] resp_addr = '0;
   int          acc_count = 0;
   logic [29:0] acc_log[$];
   logic [29:0] nxt = INIT_WORD;
   logic [29:0] prev_addr = '0;
   logic        prev_held = 1'b0;
   logic        redir_flag = 1'b0;

   always @(posedge clk) begin
      resp_valid <= acc_now;
      resp_addr  <= acc_addr;
   end
   assign rdata = resp_valid ? {2'b00, resp_addr} : junk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic reload(input logic [31:0] start);
      exp_q.delete();
      exp_q.push_back(start);
      next_push = start + 32'd4;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      junk = $urandom;
      while (exp_q.size() < 32) begin
         exp_q.push_back(next_push);
         next_push = next_push + 32'd4;
      end
   endtask

   // Monitor: inputs settle 1 time unit after posedge, so the negedge view
   // shows exactly what the DUT will act on at the coming edge.
   always @(negedge clk) begin
      logic [31:0] e;
      if (!rst_n) begin
         nxt        = INIT_WORD;
         prev_held  = 1'b0;
         redir_flag = 1'b0;
         acc_now    = 1'b0;
         acc_count  = 0;
         acc_log.delete();
      end else begin
         if (prev_held) begin
            check("held_read", {31'b0, rd}, 32'd1);
            check("held_addr", {2'b00, addr}, {2'b00, prev_addr});
         end else if (rd) begin
            check("issue_addr", {2'b00, addr}, {2'b00, nxt});
         end
         acc_now  = rd && !waitreq;
         acc_addr = addr;
         if (acc_now) begin
            acc_count++;
            acc_log.push_back(addr);
         end
         if (redirect) begin
            nxt        = redirect_pc[31:2];
            redir_flag = rd && waitreq;
         end else if (acc_now) begin
            if (!redir_flag)
               nxt = addr + 30'd1;
            redir_flag = 1'b0;
         end
         prev_held = rd && waitreq;
         prev_addr = addr;
         if (!redirect && valid && ready) begin
            if (exp_q.size() == 0) begin
               check("exp_empty", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("o_PC", pc, e);
               check("o_Inst", inst, {2'b00, e[31:2]});
            end
         end
      end
   end

   task automatic do_reset(input logic rdy);
      rst_n    = 1'b0;
      redirect = 1'b0;
      waitreq  = 1'b0;
      ready    = rdy;
      reload(INIT);
      repeat (3) step();
      check("rst_valid", {31'b0, valid}, 32'd0);
      check("rst_read", {31'b0, rd}, 32'd0);
      check("rst_addr", {2'b00, addr}, {2'b00, INIT_WORD});
      rst_n = 1'b1;
   endtask

   task automatic wait_read_at(input logic [29:0] a, input string name);
      bit ok = 0;
      for (int i = 0; i < 60; i++) begin
         if (rd && addr == a) begin
            ok = 1;
            break;
         end
         step();
      end
      if (!ok) check({name, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic find_pair(input logic [29:0] a, input logic [29:0] b, input string name);
      bit found = 0;
      for (int i = 0; i + 1 < acc_log.size(); i++) begin
         if (acc_log[i] == a) begin
            check(name, {2'b00, acc_log[i+1]}, {2'b00, b});
            found = 1;
            break;
         end
      end
      if (!found) check({name, "_missing"}, 32'd0, 32'd1);
   endtask

   initial begin
      logic [31:0] tgt;
      reload(INIT);

      // Streaming from reset with decode always ready.
      do_reset(1'b1);
      step();
      check("valid_e0", {31'b0, valid}, 32'd0);
      step();
      check("valid_e1", {31'b0, valid}, 32'd0);
      step();
      check("valid_e2", {31'b0, valid}, 32'd1);
      check("first_pc", pc, INIT);
      repeat (12) step();
      if (acc_log.size() >= 3) begin
         check("acc0", {2'b00, acc_log[0]}, 32'd0);
         check("acc1", {2'b00, acc_log[1]}, 32'd1);
         check("acc2", {2'b00, acc_log[2]}, 32'd2);
      end else begin
         check("acc_log_size", acc_log.size(), 32'd3);
      end

      // Decode stalled: queue fills to exactly QD, one pop frees one slot.
      do_reset(1'b0);
      repeat (20) step();
      check("full_acc_count", acc_count, 32'd4);
      check("full_read_low", {31'b0, rd}, 32'd0);
      ready = 1'b1;
      step();
      ready = 1'b0;
      repeat (10) step();
      check("refill_acc_count", acc_count, 32'd5);
      if (acc_log.size() >= 5)
         check("refill_addr", {2'b00, acc_log[4]}, 32'd4);
      else
         check("refill_log", acc_log.size(), 32'd5);

      // Redirect with a push and a pop in flight and three entries queued.
      do_reset(1'b0);
      for (int i = 0; i < 50 && acc_count < 4; i++) step();
      check("pre_flush_acc", acc_count, 32'd4);
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0200;
      ready       = 1'b1;
      reload(32'h0000_0200);
      step();
      redirect = 1'b0;
      check("flush_valid", {31'b0, valid}, 32'd0);
      repeat (20) step();

      // Three wait states on word 2.
      do_reset(1'b1);
      wait_read_at(30'd2, "wait2");
      waitreq = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("wait_addr", {2'b00, addr}, 32'd2);
         check("wait_read", {31'b0, rd}, 32'd1);
         step();
      end
      waitreq = 1'b0;
      repeat (20) step();

      // Redirect to 0x100 while the read of 0x10 is stalled.
      do_reset(1'b1);
      wait_read_at(30'd4, "wait4");
      waitreq = 1'b1;
      step();
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0100;
      reload(32'h0000_0100);
      step();
      redirect = 1'b0;
      step();
      waitreq = 1'b0;
      repeat (20) step();
      find_pair(30'd4, 30'h40, "redir_next_addr");

      // Fetch address wrap-around; redirect low bits must be ignored.
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFB;
      reload(32'hFFFF_FFF8);
      step();
      redirect = 1'b0;
      repeat (20) step();
      find_pair(30'h3FFF_FFFF, 30'd0, "wrap_addr");

      // Reset asserted while a read is stalled.
      waitreq = 1'b1;
      repeat (2) step();
      rst_n = 1'b0;
      reload(INIT);
      step();
      check("rst_mid_read", {31'b0, rd}, 32'd0);
      check("rst_mid_addr", {2'b00, addr}, {2'b00, INIT_WORD});
      step();
      rst_n   = 1'b1;
      waitreq = 1'b0;
      repeat (15) step();
      if (acc_log.size() > 0)
         check("restart_addr", {2'b00, acc_log[0]}, {2'b00, INIT_WORD});
      else
         check("restart_log", 32'd0, 32'd1);

      // Randomised traffic: ready, wait states and redirects (some near wrap).
      for (int n = 0; n < 3000; n++) begin
         ready   = ($urandom % 3) != 0;
         waitreq = ($urandom % 4) == 0;
         if (($urandom % 20) == 0) begin
            if ($urandom % 2)
               tgt = {20'd0, 12'($urandom_range(0, 4095))} & 32'hFFFF_FFFC;
            else
               tgt = 32'hFFFF_FF00 | (32'($urandom % 256) & 32'hFFFF_FFFC);
            redirect    = 1'b1;
            redirect_pc = tgt | 32'($urandom % 4);
            reload(tgt);
         end else begin
            redirect = 1'b0;
         end
         step();
      end
      redirect = 1'b0;
      waitreq  = 1'b0;
      ready    = 1'b1;
      repeat (20) step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

endmodule
